// File: rtl/stage_wb.sv
// Write-back stage: MEM/WB pipeline register, stall-safe load data capture,
// load alignment/extension and register-file write-port selection.
module stage_wb #(
  parameter int unsigned RD_W     = 5,
  parameter bit          X0_GUARD = 1'b1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            wb_stall,
  input  logic            wb_flush,
  input  logic            me_mem_read,
  input  logic            me_reg_write,
  input  logic [RD_W-1:0] me_rd,
  input  logic [2:0]      me_func3_code,
  input  logic [31:0]     me_alu_o,
  input  logic [31:0]     me_mem_data,
  output logic            wb_reg_write,
  output logic [RD_W-1:0] wb_rd,
  output logic [31:0]     wb_regs_data
);

  localparam int unsigned XLEN = 32;

  logic            mem_read_q, mem_read_d;
  logic            reg_write_q, reg_write_d;
  logic [RD_W-1:0] rd_q, rd_d;
  logic [2:0]      func3_q, func3_d;
  logic [XLEN-1:0] alu_q, alu_d;
  logic [XLEN-1:0] hold_data_q, hold_data_d;
  logic            hold_valid_q, hold_valid_d;

  logic [XLEN-1:0] ld_word;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_ext;

  // Next-state for MEM/WB register and the stall-capture buffer
  always_comb begin
    mem_read_d   = mem_read_q;
    reg_write_d  = reg_write_q;
    rd_d         = rd_q;
    func3_d      = func3_q;
    alu_d        = alu_q;
    hold_data_d  = hold_data_q;
    hold_valid_d = 1'b0;
    if (wb_flush) begin
      mem_read_d  = 1'b0;
      reg_write_d = 1'b0;
    end else if (!wb_stall) begin
      mem_read_d  = me_mem_read;
      reg_write_d = me_reg_write;
      rd_d        = me_rd;
      func3_d     = me_func3_code;
      alu_d       = me_alu_o;
    end
    // The memory word is only valid for one cycle; freeze it on the first stalled edge
    if (wb_stall && !wb_flush) begin
      hold_valid_d = 1'b1;
      if (!hold_valid_q) hold_data_d = me_mem_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_read_q   <= 1'b0;
      reg_write_q  <= 1'b0;
      rd_q         <= '0;
      func3_q      <= 3'b000;
      alu_q        <= '0;
      hold_data_q  <= '0;
      hold_valid_q <= 1'b0;
    end else begin
      mem_read_q   <= mem_read_d;
      reg_write_q  <= reg_write_d;
      rd_q         <= rd_d;
      func3_q      <= func3_d;
      alu_q        <= alu_d;
      hold_data_q  <= hold_data_d;
      hold_valid_q <= hold_valid_d;
    end
  end

  assign ld_word = hold_valid_q ? hold_data_q : me_mem_data;

  // Byte/half lane selection from the address offset
  always_comb begin
    ld_byte = ld_word[7:0];
    case (alu_q[1:0])
      2'd0: ld_byte = ld_word[7:0];
      2'd1: ld_byte = ld_word[15:8];
      2'd2: ld_byte = ld_word[23:16];
      2'd3: ld_byte = ld_word[31:24];
      default: ld_byte = ld_word[7:0];
    endcase
    ld_half = alu_q[1] ? ld_word[31:16] : ld_word[15:0];
  end

  always_comb begin
    ld_ext = '0;
    case (func3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_ext = {24'd0, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_ext = {16'd0, ld_half};
      3'b010:  ld_ext = ld_word;
      default: ld_ext = '0;
    endcase
  end

  assign wb_regs_data = mem_read_q ? ld_ext : alu_q;
  assign wb_reg_write = reg_write_q & ~(X0_GUARD & (rd_q == '0));
  assign wb_rd        = rd_q;

endmodule
